// File: rtl/regbank_pkg.sv
// Shared constants for the register bank and the register-destination mux.
package regbank_pkg;

  localparam int DATA_W_DEF   = 32;
  localparam int SP_RESET_DEF = 227;

  localparam logic [4:0] REG_ZERO = 5'd0;
  localparam logic [4:0] REG_SP   = 5'd29;
  localparam logic [4:0] REG_RA   = 5'd31;

  // A write only lands when enabled and not aimed at the hard-wired $zero.
  function automatic logic write_live(input logic we, input logic [4:0] addr);
    return we && (addr != REG_ZERO);
  endfunction

endpackage

// File: rtl/regbank_read_port.sv
// One registered read port of the register bank.
// Address 0 always returns 0. When REGBANK_BYPASS_EN is defined, a read of
// the register being written in the same cycle returns the new data
// (write-first); otherwise it returns the pre-write value (read-first).
module regbank_read_port
  import regbank_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [4:0]               i_addr,
  input  logic [31:0][DATA_W-1:0]  i_regs,
`ifdef REGBANK_BYPASS_EN
  input  logic                     i_we,
  input  logic [4:0]               i_waddr,
  input  logic [DATA_W-1:0]        i_wdata,
`endif
  output logic [DATA_W-1:0]        o_data
);

  logic [DATA_W-1:0] r_data;
  logic [DATA_W-1:0] w_data_next;

  // Select what the port captures at the next edge.
  always_comb begin
    w_data_next = i_regs[i_addr];
`ifdef REGBANK_BYPASS_EN
    if (write_live(i_we, i_waddr) && (i_waddr == i_addr))
      w_data_next = i_wdata;
`endif
    if (i_addr == REG_ZERO)
      w_data_next = '0;
  end

  // Output register, cleared asynchronously by reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_data <= '0;
    else          r_data <= w_data_next;
  end

  assign o_data = r_data;

endmodule

// File: rtl/regbank_32x32.sv
// 32 x DATA_W architectural register bank: one write port, two registered
// read ports. $zero is hard-wired to 0, $sp resets to SP_RESET.
// Optional macro REGBANK_BYPASS_EN selects write-first read behaviour.
module regbank_32x32
  import regbank_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int SP_RESET = SP_RESET_DEF
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              RegWrite,
  input  logic [4:0]        WriteReg,
  input  logic [DATA_W-1:0] WriteData,
  input  logic [4:0]        ReadReg1,
  input  logic [4:0]        ReadReg2,
  output logic [DATA_W-1:0] ReadData1,
  output logic [DATA_W-1:0] ReadData2
);

  logic [31:0][DATA_W-1:0] w_regs;
  logic                    w_write_live;

  assign w_write_live = write_live(RegWrite, WriteReg);

  genvar gi;
  generate
    for (gi = 0; gi < 32; gi++) begin : g_entry
      if (gi == 0) begin : g_zero
        assign w_regs[gi] = '0;
      end else begin : g_reg
        localparam logic [DATA_W-1:0] RST_VAL =
          (gi == int'(REG_SP)) ? DATA_W'(SP_RESET) : '0;
        logic [DATA_W-1:0] r_entry;
        // Storage entry: reset to its architectural value, load on decoded write.
        always_ff @(posedge clk or negedge reset_n) begin
          if (!reset_n)
            r_entry <= RST_VAL;
          else if (w_write_live && (WriteReg == 5'(gi)))
            r_entry <= WriteData;
        end
        assign w_regs[gi] = r_entry;
      end
    end
  endgenerate

  regbank_read_port #(.DATA_W(DATA_W)) u_port_a (
    .clk     (clk),
    .reset_n (reset_n),
    .i_addr  (ReadReg1),
    .i_regs  (w_regs),
`ifdef REGBANK_BYPASS_EN
    .i_we    (RegWrite),
    .i_waddr (WriteReg),
    .i_wdata (WriteData),
`endif
    .o_data  (ReadData1)
  );

  regbank_read_port #(.DATA_W(DATA_W)) u_port_b (
    .clk     (clk),
    .reset_n (reset_n),
    .i_addr  (ReadReg2),
    .i_regs  (w_regs),
`ifdef REGBANK_BYPASS_EN
    .i_we    (RegWrite),
    .i_waddr (WriteReg),
    .i_wdata (WriteData),
`endif
    .o_data  (ReadData2)
  );

endmodule

// File: tb/tb_regbank_32x32.sv
// Directed testbench for regbank_32x32 (default or REGBANK_BYPASS_EN build).
module tb_regbank_32x32;

`ifdef REGBANK_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk;
  logic        reset_n;
  logic        RegWrite;
  logic [4:0]  WriteReg;
  logic [31:0] WriteData;
  logic [4:0]  ReadReg1;
  logic [4:0]  ReadReg2;
  logic [31:0] ReadData1;
  logic [31:0] ReadData2;

  int checks = 0;
  int errors = 0;

  regbank_32x32 #(.DATA_W(32), .SP_RESET(227)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .RegWrite  (RegWrite),
    .WriteReg  (WriteReg),
    .WriteData (WriteData),
    .ReadReg1  (ReadReg1),
    .ReadReg2  (ReadReg2),
    .ReadData1 (ReadData1),
    .ReadData2 (ReadData2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance past the next rising edge; outputs are sampled 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_reg(input logic [4:0] a, input logic [31:0] d);
    RegWrite = 1'b1; WriteReg = a; WriteData = d;
    tick();
    RegWrite = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b1;
    #2 reset_n = 1'b0;
    tick();
    tick();
    checks++;
    if (ReadData1 !== 32'd0 || ReadData2 !== 32'd0) begin
      errors++;
      $display("FAIL reset_hold: rd1=%h rd2=%h expected 0 0", ReadData1, ReadData2);
    end
    ReadReg1 = 5'd29; ReadReg2 = 5'd5;
    #2 reset_n = 1'b1;
    tick();
    checks++;
    if (ReadData1 !== 32'd227) begin
      errors++;
      $display("FAIL reset_sp: rd1=%0d expected 227", ReadData1);
    end
    checks++;
    if (ReadData2 !== 32'd0) begin
      errors++;
      $display("FAIL reset_r5: rd2=%h expected 0", ReadData2);
    end
    $display("reset: rd1=%0d rd2=%0d", ReadData1, ReadData2);
  endtask

  task automatic test_basic();
    write_reg(5'd8, 32'hDEADBEEF);
    ReadReg1 = 5'd8; ReadReg2 = 5'd0;
    tick();
    checks++;
    if (ReadData1 !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL basic_a: rd1=%h expected deadbeef", ReadData1);
    end
    write_reg(5'd9, 32'hCAFEF00D);
    ReadReg1 = 5'd0; ReadReg2 = 5'd9;
    tick();
    checks++;
    if (ReadData2 !== 32'hCAFEF00D) begin
      errors++;
      $display("FAIL basic_b: rd2=%h expected cafef00d", ReadData2);
    end
    ReadReg1 = 5'd9; ReadReg2 = 5'd8;
    tick();
    checks++;
    if (ReadData1 !== 32'hCAFEF00D || ReadData2 !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL basic_swap: rd1=%h rd2=%h expected cafef00d deadbeef", ReadData1, ReadData2);
    end
    $display("basic: rd1=%h rd2=%h", ReadData1, ReadData2);
  endtask

  task automatic test_zero();
    write_reg(5'd0, 32'h12345678);
    ReadReg1 = 5'd0; ReadReg2 = 5'd0;
    tick();
    checks++;
    if (ReadData1 !== 32'd0 || ReadData2 !== 32'd0) begin
      errors++;
      $display("FAIL zero_single: rd1=%h rd2=%h expected 0 0", ReadData1, ReadData2);
    end
    RegWrite = 1'b1; WriteReg = 5'd0;
    for (int i = 0; i < 3; i++) begin
      WriteData = 32'h12345678 + i;
      tick();
      checks++;
      if (ReadData1 !== 32'd0 || ReadData2 !== 32'd0) begin
        errors++;
        $display("FAIL zero_held%0d: rd1=%h rd2=%h expected 0 0", i, ReadData1, ReadData2);
      end
    end
    RegWrite = 1'b0;
    tick();
    checks++;
    if (ReadData1 !== 32'd0 || ReadData2 !== 32'd0) begin
      errors++;
      $display("FAIL zero_after: rd1=%h rd2=%h expected 0 0", ReadData1, ReadData2);
    end
    $display("zero: rd1=%h rd2=%h", ReadData1, ReadData2);
  endtask

  task automatic test_ra_sp();
    write_reg(5'd31, 32'h00000400);
    write_reg(5'd29, 32'h000000E0);
    ReadReg1 = 5'd31; ReadReg2 = 5'd29;
    tick();
    checks++;
    if (ReadData1 !== 32'h00000400) begin
      errors++;
      $display("FAIL ra_write: rd1=%h expected 00000400", ReadData1);
    end
    checks++;
    if (ReadData2 !== 32'h000000E0) begin
      errors++;
      $display("FAIL sp_write: rd2=%h expected 000000e0", ReadData2);
    end
    $display("ra_sp: ra=%h sp=%h", ReadData1, ReadData2);
  endtask

  task automatic test_same_cycle();
    logic [31:0] exp_edge;
    exp_edge = BYP ? 32'h2 : 32'h1;
    // Port A alone
    write_reg(5'd10, 32'h1);
    RegWrite = 1'b1; WriteReg = 5'd10; WriteData = 32'h2;
    ReadReg1 = 5'd10; ReadReg2 = 5'd8;
    tick();
    RegWrite = 1'b0;
    checks++;
    if (ReadData1 !== exp_edge) begin
      errors++;
      $display("FAIL rw_a_edge: rd1=%h expected %h", ReadData1, exp_edge);
    end
    checks++;
    if (ReadData2 !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL rw_b_other: rd2=%h expected deadbeef", ReadData2);
    end
    tick();
    checks++;
    if (ReadData1 !== 32'h2) begin
      errors++;
      $display("FAIL rw_a_next: rd1=%h expected 2", ReadData1);
    end
    // Both ports
    write_reg(5'd10, 32'h1);
    RegWrite = 1'b1; WriteReg = 5'd10; WriteData = 32'h2;
    ReadReg1 = 5'd10; ReadReg2 = 5'd10;
    tick();
    RegWrite = 1'b0;
    checks++;
    if (ReadData1 !== exp_edge || ReadData2 !== exp_edge) begin
      errors++;
      $display("FAIL rw_both_edge: rd1=%h rd2=%h expected %h", ReadData1, ReadData2, exp_edge);
    end
    tick();
    checks++;
    if (ReadData1 !== 32'h2 || ReadData2 !== 32'h2) begin
      errors++;
      $display("FAIL rw_both_next: rd1=%h rd2=%h expected 2", ReadData1, ReadData2);
    end
    $display("same_cycle: bypass=%0d rd1=%h rd2=%h", BYP, ReadData1, ReadData2);
  endtask

  task automatic test_reset_midstream();
    for (int i = 1; i < 32; i++) write_reg(5'(i), 32'(i));
    ReadReg1 = 5'd17; ReadReg2 = 5'd29;
    tick();
    checks++;
    if (ReadData1 !== 32'd17 || ReadData2 !== 32'd29) begin
      errors++;
      $display("FAIL pre_reset: rd1=%0d rd2=%0d expected 17 29", ReadData1, ReadData2);
    end
    // Half-cycle pulse between edges, with a write pending.
    RegWrite = 1'b1; WriteReg = 5'd12; WriteData = 32'hFFFF0000;
    reset_n = 1'b0;
    #1;
    checks++;
    if (ReadData1 !== 32'd0 || ReadData2 !== 32'd0) begin
      errors++;
      $display("FAIL async_reset: rd1=%h rd2=%h expected 0 0", ReadData1, ReadData2);
    end
    #4 reset_n = 1'b1;
    RegWrite = 1'b0;
    for (int i = 0; i < 32; i++) begin
      logic [31:0] exp_a, exp_b;
      ReadReg1 = 5'(i); ReadReg2 = 5'(31 - i);
      exp_a = (i == 29) ? 32'd227 : 32'd0;
      exp_b = ((31 - i) == 29) ? 32'd227 : 32'd0;
      tick();
      checks++;
      if (ReadData1 !== exp_a || ReadData2 !== exp_b) begin
        errors++;
        $display("FAIL post_reset_r%0d: rd1=%h rd2=%h expected %h %h", i, ReadData1, ReadData2, exp_a, exp_b);
      end
    end
    write_reg(5'd7, 32'hA5A5A5A5);
    ReadReg1 = 5'd7; ReadReg2 = 5'd29;
    tick();
    checks++;
    if (ReadData1 !== 32'hA5A5A5A5 || ReadData2 !== 32'd227) begin
      errors++;
      $display("FAIL post_reset_write: rd1=%h rd2=%0d expected a5a5a5a5 227", ReadData1, ReadData2);
    end
    $display("reset_midstream: r7=%h sp=%0d", ReadData1, ReadData2);
  endtask

  initial begin
    reset_n = 1'b1; RegWrite = 1'b0; WriteReg = 5'd0; WriteData = 32'd0;
    ReadReg1 = 5'd0; ReadReg2 = 5'd0;
    test_reset();
    test_basic();
    test_zero();
    test_ra_sp();
    test_same_cycle();
    test_reset_midstream();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
